// File: rtl/encoder_pkg.sv
// Shared helpers for the request encoder/decoder family.
package encoder_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_encoder_rotate_first_one.sv
// Combinational first-set-bit search starting at a rotating pointer, wrapping modulo WIDTH.
module rotate_first_one
    import encoder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] pos;

    // Rotate right by ptr so the search always starts at bit 0; power-of-two WIDTH makes the index add wrap for free.
    always_comb begin
        rot = '0;
        src = '0;
        for (int i = 0; i < WIDTH; i++) begin
            src    = IDX_W'(i) + ptr_i;
            rot[i] = req_i[src];
        end
    end

    always_comb begin
        pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IDX_W'(i);
            end
        end
    end

    assign found_o = |rot;
    assign idx_o   = pos + ptr_i;

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered round-robin priority encoder: request lines in, index plus valid out, held until acked.
module rr_priority_encoder
    import encoder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] req_i,
    input  logic             ack_i,
    output logic [IDX_W-1:0] index_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic             released;
    logic             load;

    rotate_first_one #(
        .WIDTH(WIDTH)
    ) u_search (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .found_o(found),
        .idx_o  (win_idx)
    );

    // A held grant is only released by ack; ack without a grant is meaningless.
    assign released = ~valid_q | ack_i;
    assign load     = en_i & released;

    always_comb begin
        index_d = index_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                index_d = win_idx;
                ptr_d   = win_idx + 1'b1;
            end
        end else if (released) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            index_q <= index_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign index_o = index_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: directed steps push expected outputs, a monitor checks them.
module tb_rr_priority_encoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] index;
    logic       valid;

    typedef struct {
        string      name;
        logic       v;
        logic [2:0] idx;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;

    rr_priority_encoder #(.WIDTH(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .req_i  (req),
        .ack_i  (ack),
        .index_o(index),
        .valid_o(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one edge, record what the outputs must show after it.
    task automatic step(input string name, input logic r, input logic e, input logic [7:0] rq,
                        input logic a, input logic ev, input logic [2:0] ei);
        exp_t x;
        rst = r;
        en  = e;
        req = rq;
        ack = a;
        @(posedge clk);
        x.name = name;
        x.v    = ev;
        x.idx  = ei;
        q.push_back(x);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                n_tests++;
                if (valid !== x.v || index !== x.idx) begin
                    n_fail++;
                    $display("FAIL %s: got valid=%0b index=%0d, want valid=%0b index=%0d",
                             x.name, valid, index, x.v, x.idx);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b1; req = 8'hFF; ack = 1'b0;

        step("reset0",    1, 1, 8'hFF, 0, 0, 0);
        step("reset1",    1, 1, 8'hFF, 0, 0, 0);
        step("first",     0, 1, 8'hFF, 0, 1, 0);
        step("hold_ff",   0, 1, 8'hFF, 0, 1, 0);
        step("ptr_is_1",  0, 1, 8'hFF, 1, 1, 1);

        step("rot_a",     0, 1, 8'h85, 1, 1, 2);
        step("rot_b",     0, 1, 8'h85, 1, 1, 7);
        step("rot_c",     0, 1, 8'h85, 1, 1, 0);
        step("rot_d",     0, 1, 8'h85, 1, 1, 2);
        step("rot_e",     0, 1, 8'h85, 1, 1, 7);
        step("rot_f",     0, 1, 8'h85, 1, 1, 0);

        step("hold_load", 0, 1, 8'h10, 1, 1, 4);
        step("hold_1",    0, 1, 8'h10, 0, 1, 4);
        step("hold_2",    0, 1, 8'h01, 0, 1, 4);
        step("hold_3",    0, 1, 8'h01, 0, 1, 4);
        step("hold_4",    0, 0, 8'h01, 0, 1, 4);
        step("hold_5",    0, 1, 8'h01, 0, 1, 4);
        step("hold_ack",  0, 1, 8'h01, 1, 1, 0);
        step("hold_keep", 0, 1, 8'h00, 0, 1, 0);

        step("wrap_set",  0, 1, 8'h40, 1, 1, 6);
        step("wrap_7",    0, 1, 8'h81, 1, 1, 7);
        step("wrap_0",    0, 1, 8'h81, 1, 1, 0);
        step("wrap_7b",   0, 1, 8'h81, 1, 1, 7);

        step("en_set3",   0, 1, 8'h08, 1, 1, 3);
        step("en_hold",   0, 0, 8'h08, 0, 1, 3);
        step("en_drop",   0, 0, 8'h08, 1, 0, 3);
        step("en_idle",   0, 0, 8'h08, 0, 0, 3);

        step("empty",     0, 1, 8'h00, 0, 0, 3);
        step("empty_20",  0, 1, 8'h20, 0, 1, 5);
        step("ptr_kept",  0, 1, 8'hFF, 1, 1, 6);
        step("scan_wrap", 0, 1, 8'h21, 1, 1, 0);

        step("ack_drain", 0, 1, 8'h00, 1, 0, 0);
        step("ack_noval", 0, 1, 8'h00, 1, 0, 0);
        step("ack_load",  0, 1, 8'h02, 1, 1, 1);

        step("rst_hold",  0, 1, 8'h04, 0, 1, 1);
        step("rst_mid",   1, 1, 8'h04, 1, 0, 0);
        step("rst_after", 0, 1, 8'h04, 0, 1, 2);

        rst = 1'b0; en = 1'b0; req = 8'h00; ack = 1'b0;
        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending checks, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
